// File: rtl/ysyx_25040109_lsu_mc_pkg.sv
// Shared definitions for the multi-cycle load/store unit: FSM states,
// RISC-V funct3 encodings, access width codes and decode helpers.
package ysyx_25040109_lsu_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        WID_B = 2'd0,
        WID_H = 2'd1,
        WID_W = 2'd2,
        WID_D = 2'd3
    } lsu_width_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic lsu_width_e f3_width(input logic [2:0] f3);
        lsu_width_e w;
        case (f3)
            F3_B, F3_BU: w = WID_B;
            F3_H, F3_HU: w = WID_H;
            F3_W, F3_WU: w = WID_W;
            default:     w = WID_D;
        endcase
        return w;
    endfunction

    // Doubleword and unsigned-word codes only exist on a 64-bit datapath;
    // stores have no unsigned variants.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store,
                                      input logic wide);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            F3_D, F3_WU:                    ok = wide;
            default:                        ok = 1'b0;
        endcase
        return ok && !(is_store && f3[2]);
    endfunction

    function automatic logic is_misaligned(input lsu_width_e w, input logic [2:0] lo);
        logic m;
        case (w)
            WID_B:   m = 1'b0;
            WID_H:   m = lo[0];
            WID_W:   m = |lo[1:0];
            default: m = |lo;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_25040109_lsu_align.sv
// Byte-lane steering for the LSU: store data shift and strobes, load lane
// extraction with sign/zero extension. Purely combinational.
module ysyx_25040109_lsu_align
    import ysyx_25040109_lsu_mc_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [2:0]        st_funct3,
    input  logic [OFF_W-1:0]  st_offset,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [DATA_W-1:0] st_wdata_sh,
    output logic [STRB_W-1:0] st_wstrb,
    input  logic [2:0]        ld_funct3,
    input  logic [OFF_W-1:0]  ld_offset,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [7:0]        st_base_s;
    logic [DATA_W-1:0] ld_sh_s;
    logic [DATA_W-1:0] ld_keep_s;
    logic              ld_msb_s;

    // Store side: shift data and width mask up to the addressed lane.
    always_comb begin
        st_base_s = 8'h00;
        case (f3_width(st_funct3))
            WID_B:   st_base_s = 8'h01;
            WID_H:   st_base_s = 8'h03;
            WID_W:   st_base_s = 8'h0F;
            default: st_base_s = 8'hFF;
        endcase
        st_wstrb    = st_base_s[STRB_W-1:0] << st_offset;
        st_wdata_sh = st_wdata << {st_offset, 3'b000};
    end

    // Load side: bring the lane to bit 0, keep the access width, fill the rest.
    always_comb begin
        ld_sh_s   = ld_rdata >> {ld_offset, 3'b000};
        ld_keep_s = {DATA_W{1'b1}};
        ld_msb_s  = ld_sh_s[DATA_W-1];
        case (f3_width(ld_funct3))
            WID_B: begin
                ld_keep_s = DATA_W'(64'h0000_0000_0000_00FF);
                ld_msb_s  = ld_sh_s[7];
            end
            WID_H: begin
                ld_keep_s = DATA_W'(64'h0000_0000_0000_FFFF);
                ld_msb_s  = ld_sh_s[15];
            end
            WID_W: begin
                ld_keep_s = DATA_W'(64'h0000_0000_FFFF_FFFF);
                ld_msb_s  = ld_sh_s[31];
            end
            default: begin
                ld_keep_s = {DATA_W{1'b1}};
                ld_msb_s  = ld_sh_s[DATA_W-1];
            end
        endcase
        ld_data = (ld_sh_s & ld_keep_s)
                | ({DATA_W{ld_msb_s & ~ld_funct3[2]}} & ~ld_keep_s);
    end

endmodule

// File: rtl/ysyx_25040109_lsu_mc.sv
// Multi-cycle load/store unit: accepts one request at a time, checks width and
// alignment, issues a single memory access and returns one registered response.
module ysyx_25040109_lsu_mc
    import ysyx_25040109_lsu_mc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_is_store,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic                mem_rsp_err,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_misalign
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    lsu_state_e        state_r;
    logic              is_store_r;
    logic [2:0]        funct3_r;
    logic [OFF_W-1:0]  offset_r;

    logic              legal_s;
    logic              misalign_s;
    logic [ADDR_W-1:0] aligned_addr_s;
    logic [DATA_W-1:0] st_wdata_s;
    logic [STRB_W-1:0] st_wstrb_s;
    logic [DATA_W-1:0] ld_data_s;

    assign legal_s        = f3_legal(req_funct3, req_is_store, DATA_W == 64);
    assign misalign_s     = is_misaligned(f3_width(req_funct3), req_addr[2:0]);
    assign aligned_addr_s = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Store steering uses the live request; load steering uses the captured one.
    ysyx_25040109_lsu_align #(.DATA_W(DATA_W)) u_align (
        .st_funct3   (req_funct3),
        .st_offset   (req_addr[OFF_W-1:0]),
        .st_wdata    (req_wdata),
        .st_wdata_sh (st_wdata_s),
        .st_wstrb    (st_wstrb_s),
        .ld_funct3   (funct3_r),
        .ld_offset   (offset_r),
        .ld_rdata    (mem_rsp_data),
        .ld_data     (ld_data_s)
    );

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            is_store_r    <= 1'b0;
            funct3_r      <= 3'b000;
            offset_r      <= '0;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_data      <= '0;
            rsp_misalign  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        is_store_r <= req_is_store;
                        funct3_r   <= req_funct3;
                        offset_r   <= req_addr[OFF_W-1:0];
                        if (!legal_s || misalign_s) begin
                            // Unsupported code takes precedence: its width is undefined.
                            state_r      <= ST_RESP;
                            rsp_valid    <= 1'b1;
                            rsp_err      <= 1'b1;
                            rsp_misalign <= legal_s;
                            rsp_data     <= '0;
                        end else begin
                            state_r       <= ST_REQ;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= aligned_addr_s;
                            mem_wen       <= req_is_store;
                            mem_wdata     <= req_is_store ? st_wdata_s : '0;
                            mem_wstrb     <= req_is_store ? st_wstrb_s : '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_r       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        state_r      <= ST_RESP;
                        rsp_valid    <= 1'b1;
                        rsp_err      <= mem_rsp_err;
                        rsp_misalign <= 1'b0;
                        rsp_data     <= (is_store_r || mem_rsp_err) ? '0 : ld_data_s;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    req_ready     <= 1'b1;
                    mem_req_valid <= 1'b0;
                    rsp_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_lsu_mc.sv
// Bench for the LSU: 32- and 64-bit instances, directed vector table,
// reset-abandon sequence and randomized traffic against an arithmetic model.
module tb_ysyx_25040109_lsu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_rsp_err;
    logic [63:0] mem_rsp_data;

    logic        rv32, mrr32, mrv32, rv64, mrr64, mrv64;

    logic        rdy32, mqv32, wen32, rspv32, rspe32, rspm32;
    logic [31:0] maddr32, mwd32, rspd32;
    logic [3:0]  strb32;
    logic        rdy64, mqv64, wen64, rspv64, rspe64, rspm64;
    logic [31:0] maddr64;
    logic [63:0] mwd64, rspd64;
    logic [7:0]  strb64;

    ysyx_25040109_lsu_mc #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst(rst), .req_valid(rv32), .req_ready(rdy32),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .mem_req_valid(mqv32), .mem_req_ready(mrr32),
        .mem_addr(maddr32), .mem_wen(wen32), .mem_wdata(mwd32), .mem_wstrb(strb32),
        .mem_rsp_valid(mrv32), .mem_rsp_err(mem_rsp_err), .mem_rsp_data(mem_rsp_data[31:0]),
        .rsp_valid(rspv32), .rsp_err(rspe32), .rsp_data(rspd32), .rsp_misalign(rspm32)
    );

    ysyx_25040109_lsu_mc #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst), .req_valid(rv64), .req_ready(rdy64),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_req_valid(mqv64), .mem_req_ready(mrr64),
        .mem_addr(maddr64), .mem_wen(wen64), .mem_wdata(mwd64), .mem_wstrb(strb64),
        .mem_rsp_valid(mrv64), .mem_rsp_err(mem_rsp_err), .mem_rsp_data(mem_rsp_data),
        .rsp_valid(rspv64), .rsp_err(rspe64), .rsp_data(rspd64), .rsp_misalign(rspm64)
    );

    typedef struct {
        logic        req_ready, mem_req_valid, mem_wen, rsp_valid, rsp_err, rsp_misalign;
        logic [31:0] mem_addr;
        logic [63:0] mem_wdata, rsp_data;
        logic [7:0]  mem_wstrb;
    } obs_t;

    typedef struct {
        bit          w;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] mdata;
        bit          merr;
        int          rdly;
        int          sdly;
        logic [63:0] x_data;
        bit          x_err;
        bit          x_mis;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic obs_t observe(input bit w);
        obs_t o;
        if (w) begin
            o.req_ready = rdy64; o.mem_req_valid = mqv64; o.mem_wen = wen64;
            o.rsp_valid = rspv64; o.rsp_err = rspe64; o.rsp_misalign = rspm64;
            o.mem_addr = maddr64; o.mem_wdata = mwd64; o.rsp_data = rspd64;
            o.mem_wstrb = strb64;
        end else begin
            o.req_ready = rdy32; o.mem_req_valid = mqv32; o.mem_wen = wen32;
            o.rsp_valid = rspv32; o.rsp_err = rspe32; o.rsp_misalign = rspm32;
            o.mem_addr = maddr32; o.mem_wdata = {32'h0, mwd32}; o.rsp_data = {32'h0, rspd32};
            o.mem_wstrb = {4'h0, strb32};
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit w, input bit v);
        if (w) rv64 = v; else rv32 = v;
    endtask
    task automatic set_rdy(input bit w, input bit v);
        if (w) mrr64 = v; else mrr32 = v;
    endtask
    task automatic set_rsp(input bit w, input bit v);
        if (w) mrv64 = v; else mrv32 = v;
    endtask

    // Reference behaviour from the ISA rules: byte counts, modulo offsets, masks.
    task automatic model(input bit w, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] md, input bit merr,
                         output bit bad, output bit mis, output logic [31:0] maddr,
                         output logic [63:0] mwd, output logic [7:0] mstrb,
                         output logic [63:0] rd, output bit err);
        int          nb, bus, off;
        bit          legal;
        logic [63:0] busmask, raw, lmask, v;
        nb      = 1 << f3[1:0];
        bus     = w ? 8 : 4;
        off     = addr % bus;
        legal   = (f3 != 3'd7) && !(st && f3[2]) && (w || (f3 != 3'd3 && f3 != 3'd6));
        mis     = legal && ((addr % nb) != 0);
        bad     = !legal || mis;
        maddr   = addr - off;
        busmask = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        mwd     = st ? (((wd & busmask) << (8 * off)) & busmask) : 64'h0;
        mstrb   = st ? 8'((((1 << nb) - 1) << off)) : 8'h0;
        raw     = (md & busmask) >> (8 * off);
        lmask   = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v       = raw & lmask;
        if (!f3[2] && v[8*nb-1]) v = v | ~lmask;
        v   = v & busmask;
        err = bad || merr;
        rd  = (err || st) ? 64'h0 : v;
    endtask

    task automatic do_txn(input bit w, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [63:0] md, input bit merr,
                          input int rdly, input int sdly, input bit use_x,
                          input logic [63:0] x_data, input bit x_err, input bit x_mis);
        bit          bad, mis, err;
        logic [31:0] maddr;
        logic [63:0] mwd, rd;
        logic [7:0]  mstrb;
        obs_t        o;
        model(w, st, f3, addr, wd, md, merr, bad, mis, maddr, mwd, mstrb, rd, err);
        if (use_x) begin
            rd = x_data; err = x_err; mis = x_mis;
        end
        o = observe(w);
        chk("req_ready_idle", o.req_ready, 1);
        req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        set_req(w, 1'b1);
        step();
        set_req(w, 1'b0);
        o = observe(w);
        chk("req_ready_busy", o.req_ready, 0);
        if (bad) begin
            chk("err_path_no_mem", o.mem_req_valid, 0);
            chk("err_path_rsp_valid", o.rsp_valid, 1);
            chk("err_path_rsp_err", o.rsp_err, err);
            chk("err_path_misalign", o.rsp_misalign, mis);
            chk("err_path_rsp_data", o.rsp_data, rd);
        end else begin
            chk("mem_req_valid", o.mem_req_valid, 1);
            chk("mem_addr", o.mem_addr, maddr);
            chk("mem_wen", o.mem_wen, st);
            if (st) begin
                chk("mem_wdata", o.mem_wdata, mwd);
                chk("mem_wstrb", o.mem_wstrb, mstrb);
            end
            chk("rsp_valid_early", o.rsp_valid, 0);
            for (int i = 0; i < rdly; i++) begin
                step();
                o = observe(w);
                chk("mem_req_valid_hold", o.mem_req_valid, 1);
                chk("mem_addr_hold", o.mem_addr, maddr);
                if (st) chk("mem_wdata_hold", o.mem_wdata, mwd);
            end
            set_rdy(w, 1'b1);
            step();
            set_rdy(w, 1'b0);
            o = observe(w);
            chk("mem_req_valid_drop", o.mem_req_valid, 0);
            chk("rsp_valid_wait", o.rsp_valid, 0);
            for (int i = 0; i < sdly; i++) begin
                step();
                o = observe(w);
                chk("rsp_valid_wait", o.rsp_valid, 0);
                chk("mem_req_valid_wait", o.mem_req_valid, 0);
            end
            mem_rsp_data = md; mem_rsp_err = merr;
            set_rsp(w, 1'b1);
            step();
            set_rsp(w, 1'b0);
            o = observe(w);
            chk("rsp_valid", o.rsp_valid, 1);
            chk("rsp_err", o.rsp_err, err);
            chk("rsp_misalign", o.rsp_misalign, 0);
            chk("rsp_data", o.rsp_data, rd);
        end
        step();
        o = observe(w);
        chk("rsp_valid_pulse", o.rsp_valid, 0);
        chk("req_ready_back", o.req_ready, 1);
        chk("rsp_data_held", o.rsp_data, rd);
        chk("rsp_err_held", o.rsp_err, err);
    endtask

    vec_t vecs[19];

    initial begin
        obs_t o;
        rst = 1'b0;
        rv32 = 0; mrr32 = 0; mrv32 = 0; rv64 = 0; mrr64 = 0; mrv64 = 0;
        req_is_store = 0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 64'h0;
        mem_rsp_err = 0; mem_rsp_data = 64'h0;

        // w, st, f3, addr, wdata, mdata, merr, rdly, sdly, x_data, x_err, x_mis
        vecs[0]  = '{0, 0, 3'b000, 32'h1003, 64'h0, 64'h80AA_BBCC, 0, 0, 0, 64'hFFFF_FF80, 0, 0};
        vecs[1]  = '{0, 1, 3'b001, 32'h2002, 64'h1234, 64'h0, 0, 0, 0, 64'h0, 0, 0};
        vecs[2]  = '{0, 0, 3'b010, 32'h3001, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1, 1};
        vecs[3]  = '{0, 0, 3'b010, 32'h3000, 64'h0, 64'hDEAD_BEEF, 0, 5, 0, 64'hDEAD_BEEF, 0, 0};
        vecs[4]  = '{1, 0, 3'b110, 32'h4004, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 0, 64'h8765_4321, 0, 0};
        vecs[5]  = '{0, 0, 3'b011, 32'h0010, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1, 0};
        vecs[6]  = '{0, 1, 3'b100, 32'h0020, 64'h55, 64'h0, 0, 0, 0, 64'h0, 1, 0};
        vecs[7]  = '{0, 0, 3'b101, 32'h1002, 64'h0, 64'h80AA_BBCC, 0, 0, 0, 64'h80AA, 0, 0};
        vecs[8]  = '{0, 0, 3'b001, 32'h1002, 64'h0, 64'h80AA_BBCC, 0, 1, 1, 64'hFFFF_80AA, 0, 0};
        vecs[9]  = '{1, 0, 3'b011, 32'h0008, 64'h0, 64'h1122_3344_5566_7788, 0, 0, 0, 64'h1122_3344_5566_7788, 0, 0};
        vecs[10] = '{1, 0, 3'b010, 32'h4004, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 0, 64'hFFFF_FFFF_8765_4321, 0, 0};
        vecs[11] = '{0, 0, 3'b010, 32'h0020, 64'h0, 64'h1234_5678, 1, 0, 0, 64'h0, 1, 0};
        vecs[12] = '{1, 1, 3'b010, 32'h4004, 64'hAABB_CCDD, 64'h0, 0, 0, 0, 64'h0, 0, 0};
        vecs[13] = '{0, 0, 3'b110, 32'h0000, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1, 0};
        vecs[14] = '{0, 0, 3'b001, 32'h1001, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1, 1};
        vecs[15] = '{1, 0, 3'b111, 32'h0000, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1, 0};
        vecs[16] = '{0, 0, 3'b100, 32'h1001, 64'h0, 64'h80AA_BBCC, 0, 0, 0, 64'hBB, 0, 0};
        vecs[17] = '{1, 1, 3'b011, 32'h0010, 64'h0102_0304_0506_0708, 64'h0, 0, 2, 3, 64'h0, 0, 0};
        vecs[18] = '{1, 0, 3'b000, 32'h0007, 64'h0, 64'h7F11_2233_4455_6677, 0, 0, 0, 64'h7F, 0, 0};

        // Reset state of both widths.
        step(); step();
        for (int w = 0; w < 2; w++) begin
            o = observe(w[0]);
            chk("rst_req_ready", o.req_ready, 1);
            chk("rst_mem_req_valid", o.mem_req_valid, 0);
            chk("rst_mem_addr", o.mem_addr, 0);
            chk("rst_mem_wen", o.mem_wen, 0);
            chk("rst_mem_wdata", o.mem_wdata, 0);
            chk("rst_mem_wstrb", o.mem_wstrb, 0);
            chk("rst_rsp_valid", o.rsp_valid, 0);
            chk("rst_rsp_err", o.rsp_err, 0);
            chk("rst_rsp_data", o.rsp_data, 0);
            chk("rst_rsp_misalign", o.rsp_misalign, 0);
        end
        rst = 1'b1;
        step();

        foreach (vecs[i]) begin
            do_txn(vecs[i].w, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                   vecs[i].mdata, vecs[i].merr, vecs[i].rdly, vecs[i].sdly, 1'b1,
                   vecs[i].x_data, vecs[i].x_err, vecs[i].x_mis);
        end

        // Reset while waiting for the memory response, then a stray response.
        req_is_store = 0; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 64'h0;
        set_req(0, 1'b1); step(); set_req(0, 1'b0);
        set_rdy(0, 1'b1); step(); set_rdy(0, 1'b0);
        rst = 1'b0;
        #1;
        o = observe(0);
        chk("midrst_req_ready", o.req_ready, 1);
        chk("midrst_mem_req_valid", o.mem_req_valid, 0);
        chk("midrst_rsp_valid", o.rsp_valid, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        mem_rsp_data = 64'hCAFE_F00D; mem_rsp_err = 0;
        set_rsp(0, 1'b1); step(); set_rsp(0, 1'b0);
        o = observe(0);
        chk("stray_rsp_valid", o.rsp_valid, 0);
        chk("stray_req_ready", o.req_ready, 1);
        chk("stray_rsp_data", o.rsp_data, 0);
        step();
        o = observe(0);
        chk("stray_rsp_valid2", o.rsp_valid, 0);

        // Randomized traffic on both widths with idle gaps and stray responses.
        for (int n = 0; n < 200; n++) begin
            bit          w;
            logic [63:0] md, wd;
            w  = 1'($urandom_range(0, 1));
            md = {$urandom, $urandom};
            wd = {$urandom, $urandom};
            do_txn(w, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 32'hFFFF), wd, md, ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 64'h0, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                mem_rsp_data = {$urandom, $urandom};
                set_rsp(w, 1'b1); step(); set_rsp(w, 1'b0);
                o = observe(w);
                chk("idle_stray_rsp_valid", o.rsp_valid, 0);
                chk("idle_stray_req_ready", o.req_ready, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
